down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
Loadable down-counter/timer, the count-down companion to the team's loadable 4-bit up-counter. It decrements a loaded value to zero and signals terminal count. It supports one-shot and periodic (auto-reload) modes, plus pause and resume. It is used as a delay/interval generator next to the up-counter in the same datapath.

Parameters:
WIDTH, 4, bit width of count, load_data and reload register

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
load  input  1  capture load_data into count and reload register; return to IDLE
load_data  input  WIDTH  value to load
start  input  1  begin or resume counting
stop  input  1  pause counting
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled when count reaches 0
count  output  WIDTH  current counter value
busy  output  1  high while state is RUN
tc  output  1  one-cycle pulse, high exactly in the cycle where count==0 after a RUN decrement
done  output  1  sticky one-shot completion flag

Behaviour:
- Reset: one clock and one reset; reset is asynchronous and active-low (reset_n). While reset_n=0, outputs are count=0, reload_reg=0, state=IDLE, busy=0, tc=0, done=0. Reset mid-operation aborts immediately, with no completion pulse.
- States: IDLE, RUN, PAUSE. All outputs are registered; busy is decoded from the registered state.
- Priority at each edge: reset > load > stop > start > normal counting.
- load, in any state:
  - count <= load_data, reload_reg <= load_data.
  - state <= IDLE, done <= 0, tc <= 0.
  - start and stop are ignored in the same cycle.
- IDLE:
  - start with count!=0: state <= RUN, done <= 0, count unchanged.
  - start with count==0: ignored; state stays IDLE, done unchanged.
- RUN, one decrement per edge (count <= count-1):
  - Edge where count goes 1->0: tc <= 1 for the next cycle.
  - Edge after count==0 in periodic mode (auto_reload=1):
    - reload_reg!=0: count <= reload_reg, stay RUN. Period = reload_reg+1 cycles; tc repeats every reload_reg+1 cycles.
    - reload_reg==0: state <= IDLE, done <= 1.
  - Edge after count==0 in one-shot mode (auto_reload=0): state <= IDLE, done <= 1, count stays 0.
- Latency: the start edge only enters RUN. The first decrement happens on the following edge. From loaded value L, count==0 and tc=1 are visible L cycles after the cycle in which busy first goes high.
- stop in RUN: state <= PAUSE, count frozen, that cycle's decrement suppressed. Simultaneous stop+start: stop wins.
- PAUSE:
  - start: resume RUN, with the next decrement on the following edge.
  - stop: no effect.
  - tc is never asserted in PAUSE.
- done clears on load or on an accepted start.
- Arithmetic: unsigned WIDTH bits. Count never wraps below 0; the 0 state is handled explicitly as above.
- Static inputs with no start: state is held and count is unchanged.

Decomposition:
- Package down_counter_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE} dc_state_t
  - localparam default WIDTH
- Single module; a sub-module is not natural. Next-state and next-count logic are separate combinational blocks feeding one asynchronous-reset register block.

Test Plan:
1. One-shot: WIDTH=4, load 3, auto_reload=0, start pulse -> busy=1 with count 3, then 2, 1, 0. tc=1 only on the count==0 cycle. Next cycle: busy=0, done=1, count stays 0.
2. Periodic: load 2, auto_reload=1, start -> count sequence 2,1,0,2,1,0,... with a tc pulse every 3 cycles. done stays 0. busy stays 1.
3. Pause/resume: load 5, start, stop when count==3 -> count holds 3 for 4 cycles with tc=0. start -> 2,1,0, tc, done=1. Simultaneous stop+start while in RUN -> PAUSE.
4. Load overrides: during RUN at count==4, load with load_data=9 and start both high -> count=9, state IDLE, busy=0, done=0. A later start counts from 9.
5. Zero cases: load 0, start -> remains IDLE, busy=0, tc=0. Periodic mode with load 1 -> 1,0(tc), then 1,0(tc) repeating.
6. Async reset: assert reset_n=0 between clock edges mid-RUN at count==6 -> count=0, busy=0, tc=0, done=0 immediately, without waiting for a clock edge. After release, stays IDLE until load/start.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the loadable down-counter/timer.
package down_counter_pkg;

  localparam int unsigned DC_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } dc_state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and periodic modes, pause/resume,
// a one-cycle terminal-count pulse and a sticky completion flag.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DC_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  dc_state_t        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             can_reload;

  assign can_reload = auto_reload && (reload_q != '0);

  // Next-state: load beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!stop && start && (count_q != '0)) state_d = RUN;
        RUN: begin
          if (stop)                                 state_d = PAUSE;
          else if ((count_q == '0) && !can_reload)  state_d = IDLE;
        end
        PAUSE:   if (!stop && start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next count, reload value and flags.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;
    if (load) begin
      count_d  = load_data;
      reload_d = load_data;
      done_d   = 1'b0;
    end else if ((state_q == RUN) && !stop) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
        tc_d    = (count_q == WIDTH'(1));
      end else if (can_reload) begin
        count_d = reload_q;
      end else begin
        done_d  = 1'b1;
      end
    end else if ((state_q != RUN) && (state_d == RUN)) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    busy  = (state_q == RUN);
    count = count_q;
    tc    = tc_q;
    done  = done_q;
  end

endmodule
